stopwatch_button_ctrl: RTL

Front-end for the stopwatch timer: conditions two raw, asynchronous, bouncing push-buttons (START/STOP toggle and CLEAR) into clean single-cycle `start`, `stop` and `clr` pulses. It sits directly upstream of the stopwatch timer. `start`/`stop` drive the timer's start/stop inputs, and `clr` is ORed into the timer's synchronous reset. The block also tracks the timer's run state internally, so one physical button alternates between start and stop.

---
 rtl/stopwatch_button_ctrl_if.sv | 11 +
 rtl/stopwatch_button_ctrl.sv | 63 ++++++
 2 files changed

// File: rtl/stopwatch_button_ctrl_if.sv
// stopwatch_button_ctrl_if: raw button inputs and conditioned timer-control outputs.
interface stopwatch_button_ctrl_if;
  logic btn_ss_raw;
  logic btn_clr_raw;
  logic start;
  logic stop;
  logic clr;
  logic running;
  modport master(input btn_ss_raw, btn_clr_raw, output start, stop, clr, running);
  modport slave(output btn_ss_raw, btn_clr_raw, input start, stop, clr, running);
endinterface

// File: rtl/stopwatch_button_ctrl.sv
// stopwatch_button_ctrl: synchronize and debounce two buttons into start/stop/clr pulses.
module stopwatch_button_ctrl #(
  parameter int SYNC_STAGES = 2,
  parameter int DB_CYCLES   = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  stopwatch_button_ctrl_if.master        btn
);
  localparam int CW = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DB_CYCLES - 1);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q [2];
  logic [CW-1:0] cnt_q [2];
  logic [CW-1:0] cnt_d [2];
  logic [1:0] raw, sy, flip, press, db_q, db_d;
  logic start_q, stop_q, clr_q, start_d, stop_d, clr_d;
  assign raw = {btn.btn_clr_raw, btn.btn_ss_raw};
  // channel 0 is START/STOP, channel 1 is CLEAR; press is the 0->1 flip of db
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      sy[i] = sync_q[i][SYNC_STAGES-1];
      flip[i] = (sy[i] != db_q[i]) && (cnt_q[i] == LAST);
      cnt_d[i] = (sy[i] == db_q[i] || flip[i]) ? '0 : cnt_q[i] + 1'b1;
      db_d[i] = flip[i] ? sy[i] : db_q[i];
      press[i] = flip[i] & sy[i];
    end
  end
  always_comb begin
    clr_d = press[1];
    start_d = !press[1] && press[0] && state_q == IDLE;
    stop_d = !press[1] && press[0] && state_q == RUN;
    state_d = (clr_d || stop_d) ? IDLE : start_d ? RUN : state_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        sync_q[i] <= '0;
        cnt_q[i] <= '0;
      end
      db_q <= '0;
      state_q <= IDLE;
      start_q <= 1'b0;
      stop_q <= 1'b0;
      clr_q <= 1'b0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], raw[i]};
        cnt_q[i] <= cnt_d[i];
      end
      db_q <= db_d;
      state_q <= state_d;
      start_q <= start_d;
      stop_q <= stop_d;
      clr_q <= clr_d;
    end
  end
  assign btn.start = start_q;
  assign btn.stop = stop_q;
  assign btn.clr = clr_q;
  assign btn.running = state_q == RUN;
endmodule
